conv_window_3x3: RTL and testbench

- Upstream feeder for the 3x3 multiply-adder stage.
- Takes a raster-ordered pixel stream, one pixel per handshake, and keeps two row line buffers plus a 3x3 shift window.
- Emits one full 3x3 pixel window per valid output position (no padding, stride 1). Output is (IMG_HEIGHT-2) x (IMG_WIDTH-2) windows per frame.
- Window outputs connect directly to the multiply-adder pixel inputs x00..x22.

---
 rtl/conv_window_3x3.sv | 154 +++++++++++++++
 tb/tb_conv_window_3x3.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_3x3.sv
// conv_window_3x3
// Turns a raster-ordered pixel stream into 3x3 sliding windows. There is no
// padding and the stride is 1. Two line buffers hold the previous two rows.
// A 3x3 register window shifts left by one column on every accepted pixel.
// One output register stage sits on the window. The downstream side uses a
// valid/ready handshake, and a stall backpressures the input.
// The optional macro CONV_WINDOW_COORD_EN adds the win_row/win_col outputs,
// which give the window-centre coordinates.
module conv_window_3x3 #(
    parameter int PIXEL_WIDTH = 16,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [PIXEL_WIDTH-1:0] s_pixel,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic signed [PIXEL_WIDTH-1:0] x00,
    output logic signed [PIXEL_WIDTH-1:0] x01,
    output logic signed [PIXEL_WIDTH-1:0] x02,
    output logic signed [PIXEL_WIDTH-1:0] x10,
    output logic signed [PIXEL_WIDTH-1:0] x11,
    output logic signed [PIXEL_WIDTH-1:0] x12,
    output logic signed [PIXEL_WIDTH-1:0] x20,
    output logic signed [PIXEL_WIDTH-1:0] x21,
    output logic signed [PIXEL_WIDTH-1:0] x22
`ifdef CONV_WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
`endif
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    // Line buffers are plain storage. They have no reset, and stale data
    // from a previous frame is never emitted because rows 0-1 produce
    // no window.
    logic signed [PIXEL_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] r_lb1 [IMG_WIDTH];
    logic signed [PIXEL_WIDTH-1:0] r_win [3][3];

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_m_valid;
    logic          r_m_last;

    logic                          w_s_ready;
    logic                          w_in_xfer;
    logic                          w_col_last;
    logic                          w_row_last;
    logic                          w_emit;
    logic signed [PIXEL_WIDTH-1:0] w_lb0_rd;
    logic signed [PIXEL_WIDTH-1:0] w_lb1_rd;

    // A new pixel may enter whenever the output register is free or being drained.
    assign w_s_ready  = !r_m_valid || m_ready;
    assign w_in_xfer  = s_valid && w_s_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_emit     = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_lb0_rd   = r_lb0[r_col];
    assign w_lb1_rd   = r_lb1[r_col];

    // Push the incoming pixel down the two-row line buffer chain at its column.
    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_lb1[r_col] <= w_lb0_rd;
            r_lb0[r_col] <= s_pixel;
        end
    end

    // Shift the 3x3 window left and load the new right column (oldest row on top).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_in_xfer) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb1_rd;
            r_win[1][2] <= w_lb0_rd;
            r_win[2][2] <= s_pixel;
        end
    end

    // Raster position of the next pixel to be accepted. Frames follow back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_xfer) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (r_row + RW'(1));
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Output valid/last register. A transfer reloads it, and a drain with no new pixel clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_in_xfer) begin
            r_m_valid <= w_emit;
            r_m_last  <= w_emit && w_row_last && w_col_last;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

`ifdef CONV_WINDOW_COORD_EN
    // Window-centre coordinates are captured alongside each emitted window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_row <= '0;
            win_col <= '0;
        end else if (w_in_xfer && w_emit) begin
            win_row <= r_row - RW'(1);
            win_col <= r_col - CW'(1);
        end
    end
`endif

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;
    assign x00 = r_win[0][0];
    assign x01 = r_win[0][1];
    assign x02 = r_win[0][2];
    assign x10 = r_win[1][0];
    assign x11 = r_win[1][1];
    assign x12 = r_win[1][2];
    assign x20 = r_win[2][0];
    assign x21 = r_win[2][1];
    assign x22 = r_win[2][2];

endmodule

// File: tb/tb_conv_window_3x3.sv
// Self-checking bench for conv_window_3x3 on a 4x4 image. The expected windows
// come from slicing whole frames stored in a queue. Directed scenarios are
// followed by randomised pixels, valid gaps and backpressure.
module tb_conv_window_3x3;

    localparam int PW = 16;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b1;
    logic [PW-1:0] s_pixel = '0;
    logic          s_ready, m_valid, m_last;
    logic [PW-1:0] x00, x01, x02, x10, x11, x12, x20, x21, x22;
`ifdef CONV_WINDOW_COORD_EN
    logic [$clog2(H)-1:0] win_row;
    logic [$clog2(W)-1:0] win_col;
`endif

    conv_window_3x3 #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_pixel(s_pixel), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .x00(x00), .x01(x01), .x02(x02), .x10(x10), .x11(x11), .x12(x12),
        .x20(x20), .x21(x21), .x22(x22)
`ifdef CONV_WINDOW_COORD_EN
        , .win_row(win_row), .win_col(win_col)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9*PW-1:0] x;
        logic            last;
        logic [7:0]      row;
        logic [7:0]      col;
    } win_t;

    win_t          got_q[$];
    win_t          exp_q[$];
    logic [PW-1:0] frame_px[$];
    int total = 0;
    int bad   = 0;

    bit   rnd_sv = 0, rnd_mr = 0, stall_arm = 0, prev_stalled = 0, tim_pend = 0;
    int   stall_cnt = 0;
    logic tim_exp = 1'b0;
    win_t prev_w;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic win_t cur_win();
        win_t w;
        w = '0;
        w.x = {x00, x01, x02, x10, x11, x12, x20, x21, x22};
        w.last = m_last;
`ifdef CONV_WINDOW_COORD_EN
        w.row = 8'(win_row);
        w.col = 8'(win_col);
`endif
        return w;
    endfunction

    function automatic logic [PW-1:0] xk(input win_t w, input int k);
        return w.x[(8-k)*PW +: PW];
    endfunction

    // Reference: every (r,c) with r>=2, c>=2 yields rows r-2..r, cols c-2..c.
    task automatic model_frame(input int base);
        win_t w;
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                w = '0;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        w.x[(8-(dr*3+dc))*PW +: PW] = frame_px[base + (r-2+dr)*W + (c-2+dc)];
                w.last = (r == H-1) && (c == W-1);
`ifdef CONV_WINDOW_COORD_EN
                w.row = 8'(r-1);
                w.col = 8'(c-1);
`endif
                exp_q.push_back(w);
            end
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit later, the posedge applies it.
    task automatic cycle(input logic sv, input logic [PW-1:0] px, output bit acc);
        logic mr;
        win_t w;
        @(negedge clk);
        if (stall_arm && m_valid) begin
            stall_arm = 0;
            stall_cnt = 5;
        end
        if (stall_cnt > 0) mr = 1'b0;
        else if (rnd_mr) mr = ($urandom_range(0, 99) < 65);
        else mr = 1'b1;
        s_valid = sv;
        s_pixel = px;
        m_ready = mr;
        #1;
        w = cur_win();
        if (prev_stalled) begin
            chk("hold_window", w, prev_w);
            chk("hold_valid", m_valid, 1'b1);
        end
        if (tim_pend) begin
            chk("emit_timing", m_valid, tim_exp);
            tim_pend = 0;
        end
        if (m_valid && !m_ready) chk("s_ready_stalled", s_ready, 1'b0);
        else chk("s_ready_free", s_ready, 1'b1);
        if (stall_cnt > 0) stall_cnt--;
        prev_stalled = m_valid && !m_ready;
        prev_w = w;
        if (m_valid && m_ready) got_q.push_back(w);
        acc = s_valid && s_ready;
    endtask

    task automatic send_pixels(input int n, input bit tmode);
        bit acc;
        int r, c, tries;
        for (int i = 0; i < n; i++) begin
            r = (i % (W*H)) / W;
            c = i % W;
            acc = 0;
            tries = 0;
            while (!acc && tries < 200) begin
                cycle(rnd_sv ? ($urandom_range(0, 99) < 75) : 1'b1, frame_px[i], acc);
                tries++;
            end
            if (!acc) chk("accept_timeout", acc, 1'b1);
            if (acc && tmode) begin
                tim_pend = 1;
                tim_exp = (r >= 2) && (c >= 2);
            end
        end
    endtask

    task automatic drain(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, acc);
    endtask

    task automatic compare_all();
        int n;
        chk("window_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("window_%0d", i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic load_frame_a(input int add);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame_px.push_back(PW'(10*r + c + add));
    endtask

    task automatic check_reset_outputs(input string tag);
        win_t w;
        w = cur_win();
        chk({tag, "_m_valid"}, m_valid, 1'b0);
        chk({tag, "_m_last"}, m_last, 1'b0);
        chk({tag, "_window"}, w.x, '0);
`ifdef CONV_WINDOW_COORD_EN
        chk({tag, "_coord"}, {w.row, w.col}, 16'd0);
`endif
    endtask

    initial begin
        int lasts;
        win_t w0;
        int first_vals[9];
        first_vals = '{0, 1, 2, 10, 11, 12, 20, 21, 22};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_s_ready", s_ready, 1'b1);

        // Frame values and emission timing, no stall
        frame_px.delete();
        load_frame_a(0);
        model_frame(0);
        send_pixels(W*H, 1);
        drain(4);
        chk("a_count_raw", got_q.size(), 4);
        if (got_q.size() == 4) begin
            w0 = got_q[0];
            for (int k = 0; k < 9; k++) chk($sformatf("a_first_x%0d", k), xk(w0, k), PW'(first_vals[k]));
            chk("a_first_last", w0.last, 1'b0);
            chk("a_last_x00", xk(got_q[3], 0), PW'(11));
            chk("a_last_x22", xk(got_q[3], 8), PW'(33));
            chk("a_last_flag", got_q[3].last, 1'b1);
        end
        compare_all();

        // Backpressure: five stalled cycles at the first window
        stall_arm = 1;
        model_frame(0);
        send_pixels(W*H, 0);
        drain(4);
        chk("stall_consumed", stall_cnt, 0);
        compare_all();

        // Back-to-back frames, second offset by 100
        frame_px.delete();
        load_frame_a(0);
        load_frame_a(100);
        model_frame(0);
        model_frame(W*H);
        send_pixels(2*W*H, 0);
        drain(4);
        lasts = 0;
        foreach (got_q[i]) lasts += int'(got_q[i].last);
        chk("b2b_last_count", lasts, 2);
        if (got_q.size() == 8) begin
            chk("b2b_f2_x00", xk(got_q[4], 0), PW'(100));
            chk("b2b_f2_x22", xk(got_q[4], 8), PW'(122));
        end
        compare_all();

        // Reset mid-frame after nine pixels
        frame_px.delete();
        load_frame_a(0);
        send_pixels(9, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        got_q.delete();
        prev_stalled = 0;
        tim_pend = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_s_ready", s_ready, 1'b1);
        model_frame(0);
        send_pixels(W*H, 1);
        drain(4);
        compare_all();

        // Random pixels, input gaps and backpressure over three frames
        frame_px.delete();
        for (int i = 0; i < 3*W*H; i++) frame_px.push_back(PW'($urandom));
        for (int f = 0; f < 3; f++) model_frame(f*W*H);
        rnd_sv = 1;
        rnd_mr = 1;
        send_pixels(3*W*H, 0);
        drain(40);
        rnd_mr = 0;
        drain(3);
        compare_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
